// File: rtl/int_pkg.sv
// Shared interrupt id definitions; the downstream arbiter decodes the same values.
package int_pkg;
    localparam int IRQ_N_SRC = 3;
    localparam int IRQ_ID_W  = $clog2(IRQ_N_SRC + 1);

    typedef logic [IRQ_ID_W-1:0] irq_id_t;

    localparam irq_id_t IRQ_ID_NONE = irq_id_t'(0);
    localparam irq_id_t IRQ_ID_1    = irq_id_t'(1);
    localparam irq_id_t IRQ_ID_2    = irq_id_t'(2);
    localparam irq_id_t IRQ_ID_3    = irq_id_t'(3);
endpackage

// File: rtl/irq_filter.sv
// One interrupt line: synchroniser, debouncer and a rise pulse that is
// high during the cycle whose closing edge lifts the filtered level.
module irq_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic CLR_n,
    input  logic raw,
    output logic rise
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f;
    logic [CNT_W-1:0]       cnt;
    logic                   hit;

    assign s = sync_q[SYNC_STAGES-1];
    // Final mismatching cycle: the level flips on this edge.
    assign hit  = (s != f) && (cnt == CNT_LAST);
    assign rise = hit && s;

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            sync_q <= '0;
            f      <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (s == f) begin
                cnt <= '0;
            end else if (hit) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/int_req_cond.sv
// Interrupt request conditioner: per-line filtering, pending/overflow tracking,
// lowest-index priority presentation and non-nested in-service tracking.
module int_req_cond
    import int_pkg::*;
#(
    parameter int N_SRC           = IRQ_N_SRC,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ID_W            = $clog2(N_SRC + 1)
) (
    input  logic             clk,
    input  logic             CLR_n,
    input  logic [N_SRC-1:0] irq_raw,
    input  logic             take,
    input  logic             eret,
    input  logic             ovf_clr,
    output logic             req_valid,
    output logic [ID_W-1:0]  req_id,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] in_service,
    output logic [N_SRC-1:0] overflow
);
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] sel;
    logic [ID_W-1:0]  sel_id;
    logic [N_SRC-1:0] take_sel;
    logic [N_SRC-1:0] pend_kept;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_filter #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_filt (
            .clk  (clk),
            .CLR_n(CLR_n),
            .raw  (irq_raw[i]),
            .rise (rise[i])
        );
    end

    // Walk downward so the lowest-index pending source wins.
    always_comb begin
        sel    = '0;
        sel_id = ID_W'(IRQ_ID_NONE);
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                sel_id = ID_W'(i + 1);
            end
        end
    end

    assign req_valid = (|pending) && (in_service == '0);
    assign req_id    = req_valid ? sel_id : ID_W'(IRQ_ID_NONE);

    assign take_sel  = (take && req_valid) ? sel : '0;
    assign pend_kept = pending & ~take_sel;

    // A new event on a still-pending source is lost and flagged; the set beats ovf_clr.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            pending    <= '0;
            in_service <= '0;
            overflow   <= '0;
        end else begin
            pending  <= pend_kept | rise;
            overflow <= (ovf_clr ? '0 : overflow) | (pend_kept & rise);
            if (|take_sel)
                in_service <= take_sel;
            else if (eret)
                in_service <= '0;
        end
    end
endmodule

// File: tb/tb_int_req_cond.sv
// Bench for int_req_cond: reset table, directed corner sequences and a random
// run, all compared against a cycle-level model of the documented rules.
module tb_int_req_cond;
    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int IDW  = 2;

    logic           clk = 1'b0;
    logic           CLR_n = 1'b0;
    logic [N-1:0]   irq_raw = '0;
    logic           take = 1'b0;
    logic           eret = 1'b0;
    logic           ovf_clr = 1'b0;
    logic           req_valid;
    logic [IDW-1:0] req_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   in_service;
    logic [N-1:0]   overflow;

    int checks = 0;
    int errors = 0;

    int_req_cond #(
        .N_SRC(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ID_W(IDW)
    ) dut (
        .clk(clk), .CLR_n(CLR_n), .irq_raw(irq_raw), .take(take), .eret(eret),
        .ovf_clr(ovf_clr), .req_valid(req_valid), .req_id(req_id),
        .pending(pending), .in_service(in_service), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: raw history, filtered level, run length of mismatch.
    bit [SYNC-1:0] m_hist [N];
    bit [N-1:0]    m_f, m_pend, m_insv, m_ovf;
    int            m_run  [N];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_hist[i] = '0;
            m_run[i]  = 0;
        end
        m_f = '0; m_pend = '0; m_insv = '0; m_ovf = '0;
    endtask

    function automatic int model_id();
        if (m_insv != '0) return 0;
        for (int i = 0; i < N; i++)
            if (m_pend[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_step(input bit [N-1:0] r, input bit tk, input bit er, input bit oc);
        bit [N-1:0] ev;
        bit         s;
        int         id;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            s = m_hist[i][SYNC-1];
            if (s == m_f[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_f[i]   = s;
                    m_run[i] = 0;
                    ev[i]    = s;
                end
            end
            m_hist[i] = {m_hist[i][SYNC-2:0], r[i]};
        end
        id = model_id();
        if (tk && id != 0) begin
            m_pend[id-1] = 1'b0;
            m_insv       = '0;
            m_insv[id-1] = 1'b1;
        end else if (er) begin
            m_insv = '0;
        end
        if (oc) m_ovf = '0;
        m_ovf  = m_ovf | (m_pend & ev);
        m_pend = m_pend | ev;
    endtask

    task automatic cmp_model();
        chk("m_valid",   int'(req_valid),  int'(model_id() != 0));
        chk("m_id",      int'(req_id),     model_id());
        chk("m_pending", int'(pending),    int'(m_pend));
        chk("m_insv",    int'(in_service), int'(m_insv));
        chk("m_ovf",     int'(overflow),   int'(m_ovf));
    endtask

    task automatic cyc(input bit [N-1:0] r, input bit tk, input bit er, input bit oc);
        irq_raw = r; take = tk; eret = er; ovf_clr = oc;
        @(posedge clk);
        model_step(r, tk, er, oc);
        #1;
        cmp_model();
        take = 1'b0; eret = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic hold(input bit [N-1:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(r, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [N-1:0]   raw;
        bit             tk;
        bit             er;
        logic [N-1:0]   pend;
        bit             vld;
        logic [IDW-1:0] id;
        logic [N-1:0]   insv;
    } vec_t;

    vec_t tbl [10];

    initial begin
        bit [N-1:0] r;

        // Source 0 held high from edge 1: event lands on edge 6, then take and eret.
        for (int i = 0; i < 5; i++) tbl[i] = '{3'b001, 0, 0, 3'b000, 0, 2'd0, 3'b000};
        tbl[5] = '{3'b001, 0, 0, 3'b001, 1, 2'd1, 3'b000};
        tbl[6] = '{3'b001, 1, 0, 3'b000, 0, 2'd0, 3'b001};
        tbl[7] = '{3'b001, 0, 1, 3'b000, 0, 2'd0, 3'b000};
        tbl[8] = '{3'b000, 0, 0, 3'b000, 0, 2'd0, 3'b000};
        tbl[9] = '{3'b000, 0, 0, 3'b000, 0, 2'd0, 3'b000};

        model_reset();
        #12;
        chk("rst_valid",   int'(req_valid),  0);
        chk("rst_id",      int'(req_id),     0);
        chk("rst_pending", int'(pending),    0);
        chk("rst_insv",    int'(in_service), 0);
        chk("rst_ovf",     int'(overflow),   0);
        CLR_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            cyc(tbl[v].raw, tbl[v].tk, tbl[v].er, 1'b0);
            chk($sformatf("tbl%0d_pending", v), int'(pending),    int'(tbl[v].pend));
            chk($sformatf("tbl%0d_valid", v),   int'(req_valid),  int'(tbl[v].vld));
            chk($sformatf("tbl%0d_id", v),      int'(req_id),     int'(tbl[v].id));
            chk($sformatf("tbl%0d_insv", v),    int'(in_service), int'(tbl[v].insv));
        end
        hold('0, 8);

        // Glitch: synchronised level high for only 3 cycles.
        hold(3'b010, 3);
        hold('0, 12);
        chk("glitch_pending", int'(pending), 0);

        // Sources 3 and 1 together; 1 first, 3 presented in the eret cycle.
        r = 3'b101;
        hold(r, 6);
        chk("pair_pending", int'(pending), 5);
        chk("pair_id1",     int'(req_id),  1);
        cyc(r, 1'b1, 1'b0, 1'b0);
        chk("pair_insv",    int'(in_service), 1);
        chk("pair_novalid", int'(req_valid),  0);
        cyc(r, 1'b0, 1'b1, 1'b0);
        chk("pair_valid3",  int'(req_valid), 1);
        chk("pair_id3",     int'(req_id),    3);
        cyc(r, 1'b1, 1'b0, 1'b0);
        cyc(r, 1'b0, 1'b1, 1'b0);
        hold('0, 8);

        // Overflow on source 2, then clear.
        hold(3'b010, 6);
        chk("ovf_first_pending", int'(pending), 2);
        hold('0, 6);
        hold(3'b010, 6);
        chk("ovf_set",     int'(overflow), 2);
        chk("ovf_pending", int'(pending),  2);
        cyc(3'b010, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr",     int'(overflow), 0);
        cyc(3'b010, 1'b1, 1'b0, 1'b0);
        cyc(3'b010, 1'b0, 1'b1, 1'b0);
        hold('0, 8);

        // Source 1 re-fires while in service.
        hold(3'b001, 6);
        cyc(3'b001, 1'b1, 1'b0, 1'b0);
        chk("nest_insv", int'(in_service), 1);
        hold('0, 6);
        hold(3'b001, 6);
        chk("nest_pending", int'(pending),   1);
        chk("nest_valid0",  int'(req_valid), 0);
        cyc(3'b001, 1'b0, 1'b1, 1'b0);
        chk("nest_valid1",  int'(req_valid), 1);
        chk("nest_id",      int'(req_id),    1);
        cyc(3'b001, 1'b1, 1'b0, 1'b0);
        hold(3'b111, 6);
        chk("mid_pending", int'(pending),    6);
        chk("mid_insv",    int'(in_service), 1);

        // Asynchronous reset in mid-service, released with source 0 held high.
        @(posedge clk);
        #3;
        CLR_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid",   int'(req_valid),  0);
        chk("arst_id",      int'(req_id),     0);
        chk("arst_pending", int'(pending),    0);
        chk("arst_insv",    int'(in_service), 0);
        chk("arst_ovf",     int'(overflow),   0);
        irq_raw = 3'b001;
        #10;
        CLR_n = 1'b1;
        hold(3'b001, 5);
        chk("rel_pending5", int'(pending), 0);
        cyc(3'b001, 1'b0, 1'b0, 1'b0);
        chk("rel_pending6", int'(pending), 1);
        chk("rel_id",       int'(req_id),  1);

        // Random traffic against the model.
        r = 3'b001;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) r[$urandom_range(N-1)] ^= 1'b1;
            cyc(r, $urandom_range(2) == 0, $urandom_range(5) == 0, $urandom_range(15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
